// File: rtl/mem_arbiter_if.sv
// Requester, RAM-side and status signals of the two-port RAM arbiter.
// slave: the arbiter. master: the requesters and RAM around it.
interface mem_arbiter_if #(
  parameter int SIZE = 10,
  parameter int DW   = 32
);
  logic            p0_req;
  logic            p0_we;
  logic [SIZE-1:0] p0_addr;
  logic [DW-1:0]   p0_wdata;
  logic            p0_ack;

  logic            p1_req;
  logic            p1_we;
  logic [SIZE-1:0] p1_addr;
  logic [DW-1:0]   p1_wdata;
  logic            p1_ack;

  logic [DW-1:0]   o_rdata;
  logic            o_ram_we;
  logic [SIZE-1:0] o_ram_addr;
  logic [DW-1:0]   o_ram_wdata;
  logic [DW-1:0]   i_ram_rdata;
  logic            o_busy;
  logic            o_owner;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  i_ram_rdata,
    output p0_ack, p1_ack, o_rdata,
    output o_ram_we, o_ram_addr, o_ram_wdata,
    output o_busy, o_owner
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output i_ram_rdata,
    input  p0_ack, p1_ack, o_rdata,
    input  o_ram_we, o_ram_addr, o_ram_wdata,
    input  o_busy, o_owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises two req/ack requesters onto one synchronous single-port RAM.
// Each transaction takes IDLE -> ISSUE -> RESP, i.e. three cycles.
module mem_arbiter #(
  parameter int SIZE      = 10,
  parameter int DW        = 32,
  parameter int PRIO_MODE = 0
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]      state;
  logic            lastWinner;
  logic            ramWe;
  logic [SIZE-1:0] ramAddr;
  logic [DW-1:0]   ramWdata;
  logic            ack0;
  logic            ack1;
  logic            busy;
  logic            owner;

  logic            anyReq;
  logic            winner;
  logic            selWe;
  logic [SIZE-1:0] selAddr;
  logic [DW-1:0]   selWdata;

  // Round-robin only alternates under contention; a lone requester always wins.
  always_comb begin
    anyReq = bus.p0_req | bus.p1_req;
    winner = ~bus.p0_req;
    if (PRIO_MODE == 0 && bus.p0_req && bus.p1_req)
      winner = ~lastWinner;
    selWe    = winner ? bus.p1_we    : bus.p0_we;
    selAddr  = winner ? bus.p1_addr  : bus.p0_addr;
    selWdata = winner ? bus.p1_wdata : bus.p0_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lastWinner <= 1'b1;
      ramWe      <= 1'b0;
      ramAddr    <= '0;
      ramWdata   <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
      owner      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            state      <= ISSUE;
            ramWe      <= selWe;
            ramAddr    <= selAddr;
            ramWdata   <= selWdata;
            owner      <= winner;
            lastWinner <= winner;
            busy       <= 1'b1;
          end
        end
        ISSUE: begin
          state <= RESP;
          ramWe <= 1'b0;
          ack0  <= ~owner;
          ack1  <= owner;
        end
        RESP: begin
          state <= IDLE;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ramWe <= 1'b0;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ram_we    = ramWe;
  assign bus.o_ram_addr  = ramAddr;
  assign bus.o_ram_wdata = ramWdata;
  assign bus.p0_ack      = ack0;
  assign bus.p1_ack      = ack1;
  assign bus.o_busy      = busy;
  assign bus.o_owner     = owner;
  assign bus.o_rdata     = bus.i_ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: a round-robin arbiter (A) and a fixed-priority one (B),
// each in front of its own synchronous RAM model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   ackCount;

  always #5 clk = ~clk;

  mem_arbiter_if #(.SIZE(10), .DW(32)) ifA ();
  mem_arbiter_if #(.SIZE(10), .DW(32)) ifB ();

  mem_arbiter #(.SIZE(10), .DW(32), .PRIO_MODE(0)) dutA (.clk(clk), .rst(rst), .bus(ifA));
  mem_arbiter #(.SIZE(10), .DW(32), .PRIO_MODE(1)) dutB (.clk(clk), .rst(rst), .bus(ifB));

  logic [31:0] memA [1024];
  logic [31:0] memB [1024];

  always @(posedge clk) begin
    if (ifA.o_ram_we) memA[ifA.o_ram_addr] <= ifA.o_ram_wdata;
    ifA.i_ram_rdata <= memA[ifA.o_ram_addr];
    if (ifB.o_ram_we) memB[ifB.o_ram_addr] <= ifB.o_ram_wdata;
    ifB.i_ram_rdata <= memB[ifB.o_ram_addr];
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in an IDLE cycle with requests already set; walks one full grant.
  task automatic grant(input bit dB, input bit expO, input bit chkRd,
                       input logic [31:0] expRd, input string tag);
    tick(1);
    check({tag, "_issue_busy"},  dB ? ifB.o_busy  : ifA.o_busy,  64'd1);
    check({tag, "_issue_owner"}, dB ? ifB.o_owner : ifA.o_owner, {63'd0, expO});
    tick(1);
    check({tag, "_resp_ack0"}, dB ? ifB.p0_ack : ifA.p0_ack, {63'd0, !expO});
    check({tag, "_resp_ack1"}, dB ? ifB.p1_ack : ifA.p1_ack, {63'd0, expO});
    check({tag, "_resp_we"},   dB ? ifB.o_ram_we : ifA.o_ram_we, 64'd0);
    if (chkRd)
      check({tag, "_rdata"}, dB ? ifB.o_rdata : ifA.o_rdata, {32'd0, expRd});
    tick(1);
    check({tag, "_idle_acks"}, dB ? {ifB.p0_ack, ifB.p1_ack} : {ifA.p0_ack, ifA.p1_ack}, 64'd0);
    check({tag, "_idle_busy"}, dB ? ifB.o_busy : ifA.o_busy, 64'd0);
  endtask

  initial begin
    ifA.p0_req = 1'b1; ifA.p0_we = 1'b0; ifA.p0_addr = 10'd1; ifA.p0_wdata = 32'd0;
    ifA.p1_req = 1'b1; ifA.p1_we = 1'b0; ifA.p1_addr = 10'd2; ifA.p1_wdata = 32'd0;
    ifB.p0_req = 1'b0; ifB.p0_we = 1'b0; ifB.p0_addr = 10'd0; ifB.p0_wdata = 32'd0;
    ifB.p1_req = 1'b0; ifB.p1_we = 1'b0; ifB.p1_addr = 10'd0; ifB.p1_wdata = 32'd0;

    // Reset held for 10 cycles with both requests high.
    ackCount = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (ifA.p0_ack || ifA.p1_ack) ackCount++;
    end
    check("rst_no_ack", ackCount, 0);
    check("rst_outputs", {ifA.o_ram_we, ifA.p0_ack, ifA.p1_ack, ifA.o_busy, ifA.o_owner}, 64'd0);
    check("rst_addr", ifA.o_ram_addr, 64'd0);
    check("rst_wdata", ifA.o_ram_wdata, 64'd0);
    rst = 1'b1;
    grant(1'b0, 1'b0, 1'b0, 32'd0, "rst_first");
    ifA.p0_req = 1'b0;
    grant(1'b0, 1'b1, 1'b0, 32'd0, "rst_second");
    ifA.p1_req = 1'b0;

    // Port 0 write then read of addr 50.
    ifA.p0_req = 1'b1; ifA.p0_we = 1'b1; ifA.p0_addr = 10'd50; ifA.p0_wdata = 32'hDEADBEEF;
    tick(1);
    check("wr_issue_we", ifA.o_ram_we, 64'd1);
    check("wr_issue_addr", ifA.o_ram_addr, 64'd50);
    check("wr_issue_wdata", ifA.o_ram_wdata, 64'hDEADBEEF);
    check("wr_issue_ack", ifA.p0_ack, 64'd0);
    tick(1);
    check("wr_resp_we", ifA.o_ram_we, 64'd0);
    check("wr_resp_ack", ifA.p0_ack, 64'd1);
    tick(1);
    check("wr_idle_ack", ifA.p0_ack, 64'd0);
    ifA.p0_we = 1'b0;
    grant(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, "rd_p0");
    ifA.p0_req = 1'b0;

    // Port 1 read of the same word; also leaves the last winner at 1.
    ifA.p1_req = 1'b1; ifA.p1_we = 1'b0; ifA.p1_addr = 10'd50;
    grant(1'b0, 1'b1, 1'b1, 32'hDEADBEEF, "rd_p1");

    // Round-robin contention: four back-to-back writes.
    ifA.p0_req = 1'b1; ifA.p0_we = 1'b1; ifA.p0_addr = 10'd10; ifA.p0_wdata = 32'd1;
    ifA.p1_req = 1'b1; ifA.p1_we = 1'b1; ifA.p1_addr = 10'd11; ifA.p1_wdata = 32'd2;
    grant(1'b0, 1'b0, 1'b0, 32'd0, "rr_t0");
    grant(1'b0, 1'b1, 1'b0, 32'd0, "rr_t1");
    grant(1'b0, 1'b0, 1'b0, 32'd0, "rr_t2");
    grant(1'b0, 1'b1, 1'b0, 32'd0, "rr_t3");
    ifA.p0_req = 1'b0; ifA.p1_req = 1'b0;
    check("rr_mem10", memA[10], 64'd1);
    check("rr_mem11", memA[11], 64'd2);

    // Late request: p1 rises during p0's ISSUE cycle.
    ifA.p0_req = 1'b1; ifA.p0_we = 1'b0; ifA.p0_addr = 10'd10;
    tick(1);
    check("late_issue_owner", ifA.o_owner, 64'd0);
    ifA.p1_req = 1'b1; ifA.p1_we = 1'b0; ifA.p1_addr = 10'd11;
    tick(1);
    check("late_p0_ack", {ifA.p0_ack, ifA.p1_ack}, 64'b10);
    check("late_p0_rdata", ifA.o_rdata, 64'd1);
    tick(1);
    check("late_idle", {ifA.p0_ack, ifA.p1_ack, ifA.o_busy}, 64'd0);
    ifA.p0_req = 1'b0;
    grant(1'b0, 1'b1, 1'b1, 32'd2, "late_p1");
    ifA.p1_req = 1'b0;

    // Fixed priority: p0 wins five times, then p1 once p0 drops.
    ifB.p0_req = 1'b1; ifB.p0_we = 1'b1; ifB.p0_addr = 10'd5; ifB.p0_wdata = 32'd5;
    ifB.p1_req = 1'b1; ifB.p1_we = 1'b1; ifB.p1_addr = 10'd6; ifB.p1_wdata = 32'd6;
    for (int i = 0; i < 5; i++)
      grant(1'b1, 1'b0, 1'b0, 32'd0, "fp_p0");
    ifB.p0_req = 1'b0;
    grant(1'b1, 1'b1, 1'b0, 32'd0, "fp_p1");
    ifB.p1_req = 1'b0;
    check("fp_mem5", memB[5], 64'd5);
    check("fp_mem6", memB[6], 64'd6);

    // Reset during ISSUE of a p1 write to addr 20 (previously written with 3).
    ifA.p1_req = 1'b1; ifA.p1_we = 1'b1; ifA.p1_addr = 10'd20; ifA.p1_wdata = 32'd3;
    grant(1'b0, 1'b1, 1'b0, 32'd0, "pre20");
    ifA.p1_wdata = 32'd7;
    tick(1);
    check("mid_issue_we", ifA.o_ram_we, 64'd1);
    #1 rst = 1'b0;
    #1 check("mid_rst_outputs", {ifA.o_ram_we, ifA.p0_ack, ifA.p1_ack, ifA.o_busy, ifA.o_owner}, 64'd0);
    ackCount = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (ifA.p1_ack) ackCount++;
    end
    ifA.p1_req = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (ifA.p1_ack) ackCount++;
    end
    check("mid_no_ack", ackCount, 0);
    check("mid_mem20", memA[20], 64'd3);
    check("mid_after_busy", ifA.o_busy, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port 32-bit block RAM between two requesters: port 0 (the CPU) and port 1 (a loader/DMA engine).
- Accepts independent req/ack transactions on each port and serialises them onto the RAM's we/addr/wdata/rdata interface.
- Uses round-robin or fixed priority, selected by parameter.
- Sits between the requesters and the blram instance, replacing the CPU's direct RAM connection.

## Interface

Parameters:
- SIZE, 10, RAM address width (matches blram SIZE)
- DW, 32, data width
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 always wins)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- p0_req  input  1  port 0 transaction request
- p0_we  input  1  port 0 write (1) / read (0)
- p0_addr  input  SIZE  port 0 address
- p0_wdata  input  DW  port 0 write data
- p0_ack  output  1  port 0 one-cycle completion pulse
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack  same as port 0, for port 1
- o_rdata  output  DW  read data, shared by both ports; valid only during an ack of a read
- o_ram_we  output  1  to RAM i_we
- o_ram_addr  output  SIZE  to RAM i_addr
- o_ram_wdata  output  DW  to RAM i_ram_data_in
- i_ram_rdata  input  DW  from RAM o_ram_data_out; synchronous, valid one cycle after the address is sampled
- o_busy  output  1  high in ISSUE and RESP
- o_owner  output  1  port index of the current or most recent grant

## Operation

- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- **IDLE**
  - If no req is high, stay in IDLE.
  - Otherwise pick a winner:
    - PRIO_MODE=1: port 0 if p0_req, else port 1.
    - PRIO_MODE=0 with both requesting: the port that did not win last. The last-winner register resets to 1, so port 0 wins the first contended grant.
  - On the clock edge: register the winner's we/addr/wdata into o_ram_we/o_ram_addr/o_ram_wdata, set o_owner, go to ISSUE.
- **ISSUE**
  - RAM-side outputs are stable.
  - o_ram_we equals the latched we for this one cycle only.
  - Next state: RESP, with o_ram_we cleared on that edge.
- **RESP**
  - The winner's ack is high for exactly one cycle.
  - o_rdata = i_ram_rdata, combinational pass-through.
  - Next state: IDLE.
- o_ram_we is 0 in IDLE and RESP. Each RAM write is exactly one ISSUE cycle.
- Requester rules:
  - Hold req, we, addr and wdata stable from req assertion through the ack cycle.
  - After ack, either drop req or present a new transaction starting in the next cycle.
  - Fields changing before ack is a protocol violation; the arbiter only samples them in IDLE.
- A req arriving while the FSM is in ISSUE or RESP waits. It is arbitrated in the next IDLE cycle.
- Round-robin with both ports continuously requesting: grants alternate 0,1,0,1…
- Port 1 may starve under PRIO_MODE=1. This is intended.
- o_rdata during a write ack, or outside ack: undefined for consumers. It simply follows i_ram_rdata.

## Timing

- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - o_ram_we=0, o_ram_addr=0, o_ram_wdata=0.
  - p0_ack=0, p1_ack=0, o_busy=0, o_owner=0.
  - Last-winner register = 1.
- Reset asserted mid-transaction: outputs clear immediately, no ack is issued, and the transaction is lost. The requester re-issues after reset.
- Latency, with req sampled high in IDLE at edge k:
  - ISSUE occupies cycle k..k+1.
  - ack is high in cycle k+1..k+2.
  - The FSM is back in IDLE after edge k+2.
- Throughput: one transaction per 3 cycles.
- A requester holding req through its ack and then re-requesting is re-arbitrated in IDLE. In round-robin mode the other port wins if it is waiting.
- Simultaneous p0_req and p1_req rising in the same IDLE cycle are resolved by PRIO_MODE as above. Exactly one ack is issued per transaction, never both.
- All outputs except o_rdata are registered.

## Test plan

- **Reset:** hold rst low 10 cycles with both reqs high → all outputs 0, no ack. Release rst → port 0 granted first (o_owner=0).
- **Port 0 write then read:**
  - p0 writes 32'hDEADBEEF to addr 50 → o_ram_we high for exactly 1 cycle with o_ram_addr=50, p0_ack 2 cycles after req sampled.
  - p0 then reads addr 50 → p0_ack with o_rdata=32'hDEADBEEF.
- **Round-robin contention (PRIO_MODE=0):**
  - Both ports hold req continuously with writes (p0: addr 10, data 1; p1: addr 11, data 2) for 4 transactions.
  - Required: grant order 0,1,0,1, and each transaction 3 cycles.
  - RAM afterwards: mem[10]=1, mem[11]=2.
- **Fixed priority (PRIO_MODE=1):** both ports hold req for 5 transactions → all 5 acks go to p0, p1_ack stays 0. Drop p0_req → p1 granted at the next IDLE.
- **Late request:** p1_req rises during p0's ISSUE cycle → p1 is not acked until after p0_ack; p1 is granted in the following IDLE cycle.
- **Reset mid-operation:** assert rst low during ISSUE of a p1 write to addr 20 (data 7) → o_ram_we drops immediately, no p1_ack. After release, mem[20] is unchanged unless the write edge had already occurred.
